// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
//   Bundles the two handshakes of the fetch unit: the instruction-memory
//   request/acknowledge channel and the decode valid/ready channel.
//
//   imem_req    : fetch request level (fetch unit -> memory)
//   imem_addr   : fetch address, equal to the current PC (fetch unit -> memory)
//   imem_ack    : response strobe, imem_rdata valid with it (memory -> fetch unit)
//   imem_rdata  : fetched instruction word (memory -> fetch unit)
//   instr       : instruction presented to decode (fetch unit -> decode)
//   instr_valid : instr is valid (fetch unit -> decode)
//   instr_ready : decode accepts instr (decode -> fetch unit)
//
//   master : fetch-unit side
//   slave  : memory/decode side
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and single-outstanding instruction-fetch sequencer for
//   the MIPS front end. Walks IDLE -> REQ -> VALID -> UPDATE -> REQ ...,
//   fetching one word per loop, presenting it to decode, and then advancing
//   the PC either sequentially (from the external registered PC+4 adder) or
//   to a captured branch/jump target. Wrong-path fetches are squashed.
//
//   Parameters
//     RESET_PC      : PC loaded on reset
//   Ports
//     clk           : system clock, rising edge
//     reset         : synchronous active-high reset (wins over en)
//     en            : global enable; 0 freezes all state, pulses are lost
//     stall         : blocks the decode hand-off (VALID -> UPDATE)
//     branch_taken  : redirect pulse to branch_target
//     branch_target : branch destination
//     jump          : redirect pulse to jump_target (outranks branch)
//     jump_target   : jump destination
//     pc_plus_4     : registered adder output, pc + 4 one cycle late
//     pc            : current PC, drives the adder op1
//     bus           : imem req/ack channel and decode valid/ready channel
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    input  logic [31:0]            pc_plus_4,
    output logic [31:0]            pc,
    pc_fetch_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        VALID  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        instr_valid_q, instr_valid_nxt;
    logic        redir_pend, redir_pend_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;

    logic        redir_now;
    logic [31:0] redir_tgt_now;

    // Word-align a redirect target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // A pulse only counts while enabled and out of IDLE; jump outranks branch.
    assign redir_now     = en && (branch_taken || jump) && (state != IDLE);
    assign redir_tgt_now = jump ? align_word(jump_target) : align_word(branch_target);

    // Request is a pure function of state, so it holds whenever state holds.
    assign bus.imem_req    = (state == REQ);
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            redir_pend    <= 1'b0;
            redir_pc      <= 32'h0000_0000;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            instr_q       <= instr_nxt;
            instr_valid_q <= instr_valid_nxt;
            redir_pend    <= redir_pend_nxt;
            redir_pc      <= redir_pc_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr_q;
        instr_valid_nxt = instr_valid_q;
        redir_pend_nxt  = redir_pend;
        redir_pc_nxt    = redir_pc;

        if (en) begin
            // Capture any redirect seen in REQ/VALID; a later pulse overwrites.
            if (redir_now && (state == REQ || state == VALID)) begin
                redir_pend_nxt = 1'b1;
                redir_pc_nxt   = redir_tgt_now;
            end

            unique case (state)
                IDLE: begin
                    // A stray ack arriving here belongs to an abandoned fetch.
                    state_nxt = REQ;
                end

                REQ: begin
                    if (bus.imem_ack) begin
                        if (redir_pend || redir_now) begin
                            // Wrong-path word: drop it, go straight to redirect.
                            state_nxt = UPDATE;
                        end else begin
                            instr_nxt       = bus.imem_rdata;
                            instr_valid_nxt = 1'b1;
                            state_nxt       = VALID;
                        end
                    end
                end

                VALID: begin
                    // A redirect squashes the held word; if instr_ready was
                    // also high, decode has already taken it this cycle.
                    if (redir_now || (bus.instr_ready && !stall)) begin
                        instr_valid_nxt = 1'b0;
                        state_nxt       = UPDATE;
                    end
                end

                UPDATE: begin
                    // pc_plus_4 is trustworthy here: pc has been stable
                    // through REQ and VALID, longer than the adder latency.
                    if (redir_now) begin
                        pc_nxt = redir_tgt_now;
                    end else if (redir_pend) begin
                        pc_nxt = redir_pc;
                    end else begin
                        pc_nxt = pc_plus_4;
                    end
                    redir_pend_nxt = 1'b0;
                    state_nxt      = REQ;
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, stall, br, jmp;
    logic [31:0] bt, jt, pp4, pc;

    logic        rst_w, ack_w, ready_w;
    logic [31:0] rdata_w, pp4_w, pc_w;

    int n_pass  = 0;
    int n_total = 0;

    pc_fetch_unit_if fi ();
    pc_fetch_unit_if fw ();

    always #5 clk = ~clk;

    pc_fetch_unit u_dut (
        .clk           (clk),
        .reset         (rst),
        .en            (en),
        .stall         (stall),
        .branch_taken  (br),
        .branch_target (bt),
        .jump          (jmp),
        .jump_target   (jt),
        .pc_plus_4     (pp4),
        .pc            (pc),
        .bus           (fi.master)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .reset         (rst_w),
        .en            (1'b1),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .pc_plus_4     (pp4_w),
        .pc            (pc_w),
        .bus           (fw.master)
    );

    // Registered PC+4 adders, one cycle of latency.
    always @(posedge clk) begin
        pp4   <= pc + 32'd4;
        pp4_w <= pc_w + 32'd4;
    end

    assign fw.imem_ack    = ack_w;
    assign fw.imem_rdata  = rdata_w;
    assign fw.instr_ready = ready_w;

    typedef struct {
        logic        rst, en, stall, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req, e_vld;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input logic s, input logic b,
                       input logic [31:0] btg, input logic j, input logic [31:0] jtg,
                       input logic a, input logic [31:0] rd, input logic rdy,
                       input logic [31:0] xpc, input logic xreq, input logic xvld,
                       input logic [31:0] xin);
        vec_t v;
        v.rst = r; v.en = e; v.stall = s; v.br = b; v.bt = btg; v.jmp = j; v.jt = jtg;
        v.ack = a; v.rdata = rd; v.ready = rdy;
        v.e_pc = xpc; v.e_req = xreq; v.e_vld = xvld; v.e_instr = xin;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0;
        bt = '0; jt = '0;
        fi.imem_ack = 1'b0; fi.imem_rdata = '0; fi.instr_ready = 1'b0;
        rst_w = 1'b1; ack_w = 1'b0; rdata_w = '0; ready_w = 1'b0;

        //   rst en st br bt         jm jt         ack rdata        rdy  pc           req vld instr
        // reset and release
        add(1, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h0,       0, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h0,       0, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h0,       1, 0, 32'h0);
        // sequential fetch 0x11 at 0x0
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h0,       1, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h11,      1,   32'h0,       0, 1, 32'h11);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h0,       0, 0, 32'h11);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h4,       1, 0, 32'h11);
        // 0x22 at 0x4, then backpressure: ready low x3, stall x2
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h4,       1, 0, 32'h11);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h22,      0,   32'h4,       0, 1, 32'h22);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h4,       0, 1, 32'h22);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h4,       0, 1, 32'h22);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h4,       0, 1, 32'h22);
        add(0, 1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h4,       0, 1, 32'h22);
        add(0, 1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h4,       0, 1, 32'h22);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h4,       0, 0, 32'h22);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h8,       1, 0, 32'h22);
        // 0x33 at 0x8 with ack in the first REQ cycle
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h33,      1,   32'h8,       0, 1, 32'h33);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h8,       0, 0, 32'h33);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'hC,       1, 0, 32'h33);
        // branch while REQ waits; ack of 0xDEAD is discarded
        add(0, 1, 0, 1, 32'h100,   0, 32'h0,     0, 32'h0,       0,   32'hC,       1, 0, 32'h33);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'hC,       1, 0, 32'h33);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'hDEAD,    1,   32'hC,       0, 0, 32'h33);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h100,     1, 0, 32'h33);
        // jump + branch in the same VALID cycle, jump target misaligned
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h44,      0,   32'h100,     0, 1, 32'h44);
        add(0, 1, 0, 1, 32'h400,   1, 32'h203,   0, 32'h0,       1,   32'h100,     0, 0, 32'h44);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h200,     1, 0, 32'h44);
        // jump arriving in the UPDATE cycle itself
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h55,      0,   32'h200,     0, 1, 32'h55);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h200,     0, 0, 32'h55);
        add(0, 1, 0, 0, 32'h0,     1, 32'h300,   0, 32'h0,       0,   32'h300,     1, 0, 32'h55);
        // en=0 for 4 cycles in VALID; pulses, ack and ready all ignored
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h66,      0,   32'h300,     0, 1, 32'h66);
        add(0, 0, 0, 1, 32'h500,   0, 32'h0,     1, 32'h77,      1,   32'h300,     0, 1, 32'h66);
        add(0, 0, 0, 1, 32'h500,   0, 32'h0,     1, 32'h77,      1,   32'h300,     0, 1, 32'h66);
        add(0, 0, 0, 1, 32'h500,   0, 32'h0,     1, 32'h77,      1,   32'h300,     0, 1, 32'h66);
        add(0, 0, 0, 1, 32'h500,   0, 32'h0,     1, 32'h77,      1,   32'h300,     0, 1, 32'h66);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h300,     0, 0, 32'h66);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h304,     1, 0, 32'h66);
        // reset while REQ holds a pending redirect to 0x80; late ack in IDLE
        add(0, 1, 0, 1, 32'h80,    0, 32'h0,     0, 32'h0,       0,   32'h304,     1, 0, 32'h66);
        add(1, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h0,       0, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h99,      0,   32'h0,       1, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     1, 32'hAA,      0,   32'h0,       0, 1, 32'hAA);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       1,   32'h0,       0, 0, 32'hAA);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h4,       1, 0, 32'hAA);
        // branch arriving in the same cycle as the ack
        add(0, 1, 0, 1, 32'h40,    0, 32'h0,     1, 32'hBB,      1,   32'h4,       0, 0, 32'hAA);
        add(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,       0,   32'h40,      1, 0, 32'hAA);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; en = vq[i].en; stall = vq[i].stall;
            br = vq[i].br; bt = vq[i].bt; jmp = vq[i].jmp; jt = vq[i].jt;
            fi.imem_ack = vq[i].ack; fi.imem_rdata = vq[i].rdata;
            fi.instr_ready = vq[i].ready;
            @(posedge clk);
            #1;
            check("pc",          i, pc,                      vq[i].e_pc);
            check("imem_addr",   i, fi.imem_addr,            vq[i].e_pc);
            check("imem_req",    i, {31'b0, fi.imem_req},    {31'b0, vq[i].e_req});
            check("instr_valid", i, {31'b0, fi.instr_valid}, {31'b0, vq[i].e_vld});
            check("instr",       i, fi.instr,                vq[i].e_instr);
        end
        br = 1'b0; jmp = 1'b0; fi.imem_ack = 1'b0;

        // Wrap-around from RESET_PC = 0xFFFF_FFFC through one sequential loop.
        rst_w = 1'b1;
        @(posedge clk); #1;
        check("wrap_rst_pc",  0, pc_w, 32'hFFFF_FFFC);
        check("wrap_rst_req", 0, {31'b0, fw.imem_req}, 32'h0);
        rst_w = 1'b0;
        @(posedge clk); #1;
        check("wrap_req",  1, {31'b0, fw.imem_req}, 32'h1);
        check("wrap_addr", 1, fw.imem_addr, 32'hFFFF_FFFC);
        ack_w = 1'b1; rdata_w = 32'h1234_5678; ready_w = 1'b1;
        @(posedge clk); #1;
        check("wrap_vld",   2, {31'b0, fw.instr_valid}, 32'h1);
        check("wrap_instr", 2, fw.instr, 32'h1234_5678);
        ack_w = 1'b0;
        @(posedge clk); #1;
        check("wrap_vld",  3, {31'b0, fw.instr_valid}, 32'h0);
        check("wrap_pc",   3, pc_w, 32'hFFFF_FFFC);
        ready_w = 1'b0;
        @(posedge clk); #1;
        check("wrap_pc",   4, pc_w, 32'h0);
        check("wrap_addr", 4, fw.imem_addr, 32'h0);
        check("wrap_req",  4, {31'b0, fw.imem_req}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
